// File: rtl/vga_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : vga_scan_ctrl
//  Description : Raster timing generator and final pixel output stage.
//                Scans hcnt/vcnt, broadcasts the scan address to the layer
//                renderers, delays sync/blanking to match renderer latency,
//                selects the pixel color and emits a per-frame tick.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_scan_ctrl #(
   parameter int          H_ACTIVE = 1280,
   parameter int          H_FP     = 48,
   parameter int          H_SYNC   = 112,
   parameter int          H_BP     = 248,
   parameter int          V_ACTIVE = 1024,
   parameter int          V_FP     = 1,
   parameter int          V_SYNC   = 3,
   parameter int          V_BP     = 38,
   parameter logic        SYNC_POL = 1'b1,
   parameter int          PIPE     = 1,
   parameter logic [11:0] BG_COLOR = 12'h000
) (
   input  logic        clk,
   input  logic        rst,
   output logic [10:0] xaddr,
   output logic [9:0]  yaddr,
   output logic        addr_valid,
   input  logic        iswall,
   input  logic [11:0] wall_color,
   output logic        vga_hs,
   output logic        vga_vs,
   output logic [3:0]  vga_r,
   output logic [3:0]  vga_g,
   output logic [3:0]  vga_b,
   output logic        frame_tick
);

   localparam int          c_H_TOT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int          c_V_TOT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam logic [10:0] c_H_LAST   = 11'(c_H_TOT - 1);
   localparam logic [10:0] c_V_LAST   = 11'(c_V_TOT - 1);
   localparam logic [10:0] c_H_ACT    = 11'(H_ACTIVE);
   localparam logic [10:0] c_V_ACT    = 11'(V_ACTIVE);
   localparam logic [10:0] c_HS_BEG   = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] c_HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [10:0] c_VS_BEG   = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] c_VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

   logic [10:0]     r_hcnt;
   logic [10:0]     r_vcnt;
   logic            w_de;
   logic            w_hs_raw;
   logic            w_vs_raw;
   logic [PIPE-1:0] r_de_sr;
   logic [PIPE-1:0] r_hs_sr;
   logic [PIPE-1:0] r_vs_sr;
   logic            w_de_d;
   logic            w_hs_d;
   logic            w_vs_d;
   logic [11:0]     w_color;

   // Horizontal/vertical scan counters; vcnt advances as hcnt wraps
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hcnt <= 11'd0;
         r_vcnt <= 11'd0;
      end else if (r_hcnt == c_H_LAST) begin
         r_hcnt <= 11'd0;
         if (r_vcnt == c_V_LAST) begin
            r_vcnt <= 11'd0;
         end else begin
            r_vcnt <= r_vcnt + 11'd1;
         end
      end else begin
         r_hcnt <= r_hcnt + 11'd1;
      end
   end

   // Undelayed raster flags, straight from the counter registers
   assign w_de       = (r_hcnt < c_H_ACT) && (r_vcnt < c_V_ACT);
   assign w_hs_raw   = (r_hcnt >= c_HS_BEG) && (r_hcnt <= c_HS_END);
   assign w_vs_raw   = (r_vcnt >= c_VS_BEG) && (r_vcnt <= c_VS_END);

   assign xaddr      = r_hcnt;
   assign yaddr      = (r_vcnt < c_V_ACT) ? r_vcnt[9:0] : 10'd0;
   assign addr_valid = w_de;
   assign frame_tick = (r_hcnt == 11'd0) && (r_vcnt == c_V_ACT);

   // Delay line matching the renderer latency so sync/blank line up with color
   generate
      if (PIPE == 1) begin : g_pipe_single
         always_ff @(posedge clk) begin
            if (rst) begin
               r_de_sr <= '0;
               r_hs_sr <= '0;
               r_vs_sr <= '0;
            end else begin
               r_de_sr <= w_de;
               r_hs_sr <= w_hs_raw;
               r_vs_sr <= w_vs_raw;
            end
         end
      end else begin : g_pipe_multi
         always_ff @(posedge clk) begin
            if (rst) begin
               r_de_sr <= '0;
               r_hs_sr <= '0;
               r_vs_sr <= '0;
            end else begin
               r_de_sr <= {r_de_sr[PIPE-2:0], w_de};
               r_hs_sr <= {r_hs_sr[PIPE-2:0], w_hs_raw};
               r_vs_sr <= {r_vs_sr[PIPE-2:0], w_vs_raw};
            end
         end
      end
   endgenerate

   assign w_de_d  = r_de_sr[PIPE-1];
   assign w_hs_d  = r_hs_sr[PIPE-1];
   assign w_vs_d  = r_vs_sr[PIPE-1];

   // Blanking forces black; inside the window the renderer hit selects color
   assign w_color = w_de_d ? (iswall ? wall_color : BG_COLOR) : 12'h000;

   // Registered VGA pin drivers
   always_ff @(posedge clk) begin
      if (rst) begin
         vga_r  <= 4'd0;
         vga_g  <= 4'd0;
         vga_b  <= 4'd0;
         vga_hs <= ~SYNC_POL;
         vga_vs <= ~SYNC_POL;
      end else begin
         vga_r  <= w_color[11:8];
         vga_g  <= w_color[7:4];
         vga_b  <= w_color[3:0];
         vga_hs <= w_hs_d ? SYNC_POL : ~SYNC_POL;
         vga_vs <= w_vs_d ? SYNC_POL : ~SYNC_POL;
      end
   end

endmodule
`default_nettype wire

// File: doc/vga_scan_ctrl.md
# vga_scan_ctrl

Raster timing generator and final pixel output stage for the Tetris display. It counts horizontal and vertical scan positions and broadcasts them as `xaddr`/`yaddr` to the layer renderers, such as the wall/background layer. Each renderer returns a registered hit flag plus a color one cycle later. This block delays sync and blanking to match that latency, selects the pixel color, and drives the VGA pins. It also emits a once-per-frame tick for game-logic pacing.

## Interface
- `H_ACTIVE`, 1280, visible pixels per line
- `H_FP`, 48, horizontal front porch, in pixels
- `H_SYNC`, 112, hsync pulse width, in pixels
- `H_BP`, 248, horizontal back porch, in pixels
- `V_ACTIVE`, 1024, visible lines
- `V_FP`, 1, vertical front porch, in lines
- `V_SYNC`, 3, vsync pulse width, in lines
- `V_BP`, 38, vertical back porch, in lines
- `SYNC_POL`, 1, active level of hsync and vsync
- `PIPE`, 1, renderer latency in cycles; legal range 1..4
- `BG_COLOR`, 12'h000, color of non-wall active pixels

Ports:
- `clk`  in  1  pixel clock, 108 MHz for the defaults
- `rst`  in  1  synchronous, active-high reset
- `xaddr`  out  11  current horizontal count
- `yaddr`  out  10  current line number while the line is visible, else 0
- `addr_valid`  out  1  current position is in the active region; undelayed
- `iswall`  in  1  renderer hit flag, sampled `PIPE` cycles after its address
- `wall_color`  in  12  RGB444 color used when `iswall` is high
- `vga_hs`  out  1  horizontal sync
- `vga_vs`  out  1  vertical sync
- `vga_r`, `vga_g`, `vga_b`  out  4 each  pixel color
- `frame_tick`  out  1  one-cycle pulse per frame at the start of vertical blanking

## Operation
- Totals: H_TOT = 1688 and V_TOT = 1066 for the defaults.
- Counters:
  - `hcnt` runs 0..H_TOT-1 and wraps to 0.
  - `vcnt` increments in the cycle `hcnt` wraps.
  - `vcnt` wraps to 0 when it increments from V_TOT-1.
- Address outputs:
  - `xaddr` = `hcnt`.
  - `yaddr` = `vcnt[9:0]` when `vcnt` < V_ACTIVE, else 0.
- Undelayed flags, all derived from the counter registers:
  - `de` = (`hcnt` < H_ACTIVE) && (`vcnt` < V_ACTIVE); `addr_valid` = `de`.
  - `hs_raw` is high for `hcnt` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. [1328, 1439].
  - `vs_raw` is high for `vcnt` in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. [1025, 1027].
- Delay line: `de`, `hs_raw` and `vs_raw` pass through a `PIPE`-stage shift register, giving `de_d`, `hs_d` and `vs_d`.
- Output register, updated every cycle:
  - Color = `de_d` ? (`iswall` ? `wall_color` : `BG_COLOR`) : 12'h000.
  - `vga_r` = color[11:8], `vga_g` = color[7:4], `vga_b` = color[3:0].
  - `vga_hs` = `hs_d` ? SYNC_POL : ~SYNC_POL; `vga_vs` is formed the same way from `vs_d`.
- Blanking always forces black, regardless of `iswall`.
- `frame_tick` = (`hcnt` == 0) && (`vcnt` == V_ACTIVE). It is undelayed and high for exactly one cycle per frame.

## Timing
- Reset values:
  - `hcnt` = 0, `vcnt` = 0, all delay stages = 0.
  - `vga_r`/`vga_g`/`vga_b` = 0.
  - `vga_hs` = `vga_vs` = ~SYNC_POL.
  - `frame_tick` = 0.
  - While `rst` is high, `xaddr` = 0, `yaddr` = 0 and `addr_valid` = 1; these follow the counter registers.
- First cycle after `rst` falls: counters are at (0,0) and `addr_valid` = 1.
- Alignment: if the counters are at (h,v) in cycle t, then:
  - `iswall`/`wall_color` are sampled at t+PIPE;
  - `vga_*` show pixel (h,v) in cycle t+PIPE+1.
  - Sync, blanking and color stay mutually aligned for every `PIPE` value.
- Line period is 1688 cycles. Frame period is 1,799,408 cycles.
- Reset mid-frame:
  - Counters and pipeline clear on the next edge.
  - A sync pulse in progress terminates immediately.
  - No partial `frame_tick` is produced.
- `iswall` outside the active window (after delay) is ignored.
- Renderer inputs need no handshake; the block samples them every cycle.

## Test plan
- Reset values: hold `rst` for 5 cycles → all reset values hold; 1 cycle after release, `xaddr` = 0, `yaddr` = 0, `addr_valid` = 1; `vga_hs` = `vga_vs` = 0.
- Line and frame periods: run one frame with default parameters → consecutive `vga_hs` rising edges are 1688 cycles apart; each hs pulse is 112 cycles wide; the first hs rising edge is 1330 cycles after `rst` release (1328 + PIPE + 1); each vsync pulse is 3×1688 = 5064 cycles wide; vs rising edges are 1,799,408 cycles apart.
- Color mux with PIPE=1: drive `iswall` high only at the sampling cycles for `xaddr` 470..829, with `wall_color` = 12'h333 → `vga_r`/`vga_g`/`vga_b` = 3/3/3 for exactly those 360 pixel slots, and 0 elsewhere on the line.
- Blanking override: hold `iswall` = 1 and `wall_color` = 12'hFFF constantly → RGB = F/F/F while the delayed `de` is 1, and 0 in every blanking cycle, including all of line 1024.
- `frame_tick`: run two frames → the first pulse comes 1,728,512 cycles after `rst` release, it is 1 cycle wide, and the next pulse comes 1,799,408 cycles later.
- Mid-frame reset: assert `rst` with `hcnt` = 1400 and `vcnt` = 1026, i.e. inside both sync pulses → both syncs go inactive on the next edge; after release, counting restarts at (0,0); no spurious `frame_tick` is produced; repeat with PIPE=3 and confirm alignment of +4 cycles.
